// File: rtl/alu_writeback_unit_if.sv
// Request/writeback bus for alu_writeback_unit.
// master: the requester that issues operations and observes writebacks.
// slave: the execution unit.
interface alu_writeback_unit_if #(
  parameter int WIDTH = 16,
  parameter int NREG  = 16,
  parameter int AW    = $clog2(NREG)
);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            op;
  logic [AW-1:0]         rd;
  logic [WIDTH-1:0]      rs1;
  logic [WIDTH-1:0]      rs2;
  logic                  cin;
  logic                  bin;
  logic                  wb_valid;
  logic [AW-1:0]         wb_rd;
  logic [WIDTH-1:0]      wb_data;
  logic [WIDTH-1:0]      mul_hi;
  logic                  flag_c;
  logic                  flag_z;
  logic [NREG*WIDTH-1:0] regs_flat;

  modport master (
    output in_valid, op, rd, rs1, rs2, cin, bin,
    input  in_ready, wb_valid, wb_rd, wb_data, mul_hi, flag_c, flag_z, regs_flat
  );

  modport slave (
    input  in_valid, op, rd, rs1, rs2, cin, bin,
    output in_ready, wb_valid, wb_rd, wb_data, mul_hi, flag_c, flag_z, regs_flat
  );
endinterface

// File: rtl/alu_writeback_unit.sv
// Clocked ALU with register-file writeback.
// Handles ADD/SUB/MOV in one execute cycle and unsigned MUL as a
// WIDTH-cycle radix-2 shift-add, then writes the result into an
// NREG x WIDTH register file that is exported flat.
module alu_writeback_unit #(
  parameter  int WIDTH = 16,
  parameter  int NREG  = 16,
  localparam int AW    = $clog2(NREG)
) (
  input logic               clk,
  input logic               rst,
  alu_writeback_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, WB} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_MOV} op_t;

  state_t             state_q, state_d;
  op_t                op_q, op_d;
  logic [AW-1:0]      rd_q, rd_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               cin_q, cin_d;
  logic               bin_q, bin_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [AW-1:0]      wb_rd_q, wb_rd_d;
  logic [WIDTH-1:0]   wb_data_q, wb_data_d;
  logic [WIDTH-1:0]   mul_hi_q, mul_hi_d;
  logic               flag_c_q, flag_c_d;
  logic               flag_z_q, flag_z_d;
  logic [WIDTH-1:0]   regs_q [NREG];
  logic [WIDTH-1:0]   regs_d [NREG];

  logic [WIDTH:0]     res;
  logic [WIDTH:0]     mul_sum;

  // Next-state, operand capture, execute and writeback computation
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    a_d       = a_q;
    b_d       = b_q;
    cin_d     = cin_q;
    bin_d     = bin_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    mul_hi_d  = mul_hi_q;
    flag_c_d  = flag_c_q;
    flag_z_d  = flag_z_q;
    regs_d    = regs_q;
    res       = '0;
    mul_sum   = '0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d    = op_t'(bus.op);
          rd_d    = bus.rd;
          a_d     = bus.rs1;
          b_d     = bus.rs2;
          cin_d   = bus.cin;
          bin_d   = bus.bin;
          acc_d   = {{WIDTH{1'b0}}, bus.rs2};
          cnt_d   = '0;
          state_d = (op_t'(bus.op) == OP_MUL) ? MUL : EXEC;
        end
      end

      MUL: begin
        // Multiplier bits shift out of the low half while partial sums enter the high half.
        mul_sum = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q})
                           : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d   = cnt_q + 5'd1;
        // MUL finishes through EXEC so result selection and flag update share one path.
        if (cnt_q == 5'(WIDTH - 1)) begin
          state_d = EXEC;
        end
      end

      EXEC: begin
        case (op_q)
          OP_ADD: res = {1'b0, a_q} + {1'b0, b_q} + (WIDTH+1)'(cin_q);
          OP_SUB: res = {1'b0, a_q} - {1'b0, b_q} - (WIDTH+1)'(bin_q);
          OP_MUL: begin
            res      = {1'b0, acc_q[WIDTH-1:0]};
            mul_hi_d = acc_q[2*WIDTH-1:WIDTH];
          end
          default: res = {1'b0, a_q};
        endcase
        wb_rd_d   = rd_q;
        wb_data_d = res[WIDTH-1:0];
        flag_c_d  = res[WIDTH];
        flag_z_d  = (res[WIDTH-1:0] == '0);
        state_d   = WB;
      end

      WB: begin
        regs_d[wb_rd_q] = wb_data_q;
        state_d         = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= OP_ADD;
      rd_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cin_q     <= 1'b0;
      bin_q     <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      mul_hi_q  <= '0;
      flag_c_q  <= 1'b0;
      flag_z_q  <= 1'b0;
      regs_q    <= '{default: '0};
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cin_q     <= cin_d;
      bin_q     <= bin_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      mul_hi_q  <= mul_hi_d;
      flag_c_q  <= flag_c_d;
      flag_z_q  <= flag_z_d;
      regs_q    <= regs_d;
    end
  end

  // Output drive: handshake and writeback strobes decode directly from state
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.wb_valid  = (state_q == WB);
    bus.wb_rd     = wb_rd_q;
    bus.wb_data   = wb_data_q;
    bus.mul_hi    = mul_hi_q;
    bus.flag_c    = flag_c_q;
    bus.flag_z    = flag_z_q;
    bus.regs_flat = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      bus.regs_flat[i*WIDTH +: WIDTH] = regs_q[i];
    end
  end

endmodule

// File: tb/tb_alu_writeback_unit.sv
// Self-checking bench for alu_writeback_unit: vector table driven through a
// scoreboard, plus hand sequences for busy-period requests and mid-MUL reset.
module tb_alu_writeback_unit;
  localparam int W  = 16;
  localparam int N  = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_writeback_unit_if #(.WIDTH(W), .NREG(N)) bus ();
  alu_writeback_unit #(.WIDTH(W), .NREG(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] rd;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          bin;
    logic [W-1:0]  data;
    logic          c;
    logic [W-1:0]  hi;
  } vec_t;

  typedef struct {
    logic [AW-1:0] rd;
    logic [W-1:0]  data;
    logic          c;
    logic          z;
    logic [W-1:0]  hi;
  } exp_t;

  vec_t         vecs [12];
  exp_t         sbq [$];
  logic [W-1:0] mregs [N];
  int           pass_cnt = 0;
  int           total = 0;

  task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic logic [N*W-1:0] flat_regs();
    logic [N*W-1:0] f;
    f = '0;
    for (int i = 0; i < N; i++) f[i*W +: W] = mregs[i];
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request in the current cycle (T); returns in cycle T+1
  task automatic issue(input vec_t v, input bit push);
    exp_t e;
    check("in_ready_at_accept", 256'(bus.in_ready), 256'(1));
    bus.in_valid = 1'b1;
    bus.op  = v.op;
    bus.rd  = v.rd;
    bus.rs1 = v.a;
    bus.rs2 = v.b;
    bus.cin = v.cin;
    bus.bin = v.bin;
    if (push) begin
      e.rd = v.rd; e.data = v.data; e.c = v.c; e.z = (v.data == '0); e.hi = v.hi;
      sbq.push_back(e);
    end
    tick();
    bus.in_valid = 1'b0;
    bus.op  = 2'($urandom);
    bus.rd  = AW'($urandom);
    bus.rs1 = W'($urandom);
    bus.rs2 = W'($urandom);
    bus.cin = 1'($urandom);
    bus.bin = 1'($urandom);
  endtask

  task automatic pop_and_compare(input string name);
    exp_t e;
    if (sbq.size() == 0) begin
      total++;
      $display("FAIL %s_scoreboard actual=empty required=entry", name);
    end else begin
      e = sbq.pop_front();
      check({name, "_wb_rd"},   256'(bus.wb_rd),   256'(e.rd));
      check({name, "_wb_data"}, 256'(bus.wb_data), 256'(e.data));
      check({name, "_flag_c"},  256'(bus.flag_c),  256'(e.c));
      check({name, "_flag_z"},  256'(bus.flag_z),  256'(e.z));
      check({name, "_mul_hi"},  256'(bus.mul_hi),  256'(e.hi));
      mregs[e.rd] = e.data;
    end
  endtask

  // Called in cycle T+1; waits for the writeback and checks latency and register file
  task automatic wait_wb(input int exp_lat, input string name);
    int lat;
    lat = 1;
    while (bus.wb_valid !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
    check({name, "_latency"}, 256'(lat), 256'(exp_lat));
    if (bus.wb_valid === 1'b1) pop_and_compare(name);
    tick();
    check({name, "_wb_pulse_end"}, 256'(bus.wb_valid), 256'(0));
    check({name, "_in_ready"},     256'(bus.in_ready), 256'(1));
    check({name, "_regs_flat"},    bus.regs_flat, flat_regs());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   wbs, wb_k;
    bit   rdy_seen, wb_seen;

    bus.in_valid = 1'b0;
    bus.op = '0; bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0; bus.cin = 1'b0; bus.bin = 1'b0;
    for (int i = 0; i < N; i++) mregs[i] = '0;

    //          op     rd     rs1       rs2       cin   bin   data      c     mul_hi
    vecs[0]  = '{2'd0, 4'd3,  16'd120,  16'd10,   1'b0, 1'b1, 16'd130,  1'b0, 16'h0000};
    vecs[1]  = '{2'd0, 4'd5,  16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 16'h0000};
    vecs[2]  = '{2'd1, 4'd6,  16'd5,    16'd10,   1'b1, 1'b0, 16'hFFFB, 1'b1, 16'h0000};
    vecs[3]  = '{2'd2, 4'd7,  16'd120,  16'd10,   1'b1, 1'b1, 16'd1200, 1'b0, 16'h0000};
    vecs[4]  = '{2'd2, 4'd8,  16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'h0001, 1'b0, 16'hFFFE};
    vecs[5]  = '{2'd1, 4'd9,  16'd10,   16'd10,   1'b0, 1'b0, 16'h0000, 1'b0, 16'hFFFE};
    vecs[6]  = '{2'd3, 4'd15, 16'd42,   16'h1234, 1'b1, 1'b1, 16'd42,   1'b0, 16'hFFFE};
    vecs[7]  = '{2'd0, 4'd0,  16'h8000, 16'h7FFF, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hFFFE};
    vecs[8]  = '{2'd1, 4'd1,  16'h0000, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 1'b1, 16'hFFFE};
    vecs[9]  = '{2'd1, 4'd2,  16'd7,    16'd6,    1'b0, 1'b1, 16'h0000, 1'b0, 16'hFFFE};
    vecs[10] = '{2'd2, 4'd4,  16'h1234, 16'h0010, 1'b0, 1'b0, 16'h2340, 1'b0, 16'h0001};
    vecs[11] = '{2'd0, 4'd3,  16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 16'h0001};

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready",  256'(bus.in_ready), 256'(1));
    check("rst_wb_valid",  256'(bus.wb_valid), 256'(0));
    check("rst_wb_data",   256'(bus.wb_data),  256'(0));
    check("rst_wb_rd",     256'(bus.wb_rd),    256'(0));
    check("rst_flags",     256'({bus.flag_c, bus.flag_z}), 256'(0));
    check("rst_mul_hi",    256'(bus.mul_hi),   256'(0));
    check("rst_regs_flat", bus.regs_flat, flat_regs());

    // Vector table
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i], 1'b1);
      wait_wb((vecs[i].op == 2'd2) ? W + 2 : 2, $sformatf("vec%0d", i));
    end

    // Requests during a MUL are ignored; single writeback; next accept at T+19
    v = '{2'd2, 4'd10, 16'd3, 16'd5, 1'b0, 1'b0, 16'd15, 1'b0, 16'h0000};
    issue(v, 1'b1);
    wbs = 0; wb_k = -1; rdy_seen = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      bus.in_valid = (k >= 2 && k <= 17 && (k % 3 == 0));
      bus.op  = 2'd0;
      bus.rd  = 4'd11;
      bus.rs1 = W'($urandom);
      if (k <= 18 && bus.in_ready) rdy_seen = 1'b1;
      if (bus.wb_valid) begin
        wbs++;
        wb_k = k;
        pop_and_compare("busy_mul");
      end
      if (k == 19) check("busy_next_accept_ready", 256'(bus.in_ready), 256'(1));
      if (k < 19) tick();
    end
    bus.in_valid = 1'b0;
    check("busy_wb_count",   256'(wbs),      256'(1));
    check("busy_wb_cycle",   256'(wb_k),     256'(18));
    check("busy_ready_low",  256'(rdy_seen), 256'(0));
    tick();
    check("busy_regs_flat",  bus.regs_flat, flat_regs());

    // Reset in MUL cycle 8 aborts the multiply
    v = '{2'd2, 4'd12, 16'h00FF, 16'h0101, 1'b0, 1'b0, 16'hFFFF, 1'b0, 16'h0000};
    issue(v, 1'b0);
    for (int k = 1; k < 8; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) mregs[i] = '0;
    check("abort_in_ready",  256'(bus.in_ready), 256'(1));
    check("abort_wb_valid",  256'(bus.wb_valid), 256'(0));
    check("abort_wb_data",   256'(bus.wb_data),  256'(0));
    check("abort_wb_rd",     256'(bus.wb_rd),    256'(0));
    check("abort_flags",     256'({bus.flag_c, bus.flag_z}), 256'(0));
    check("abort_mul_hi",    256'(bus.mul_hi),   256'(0));
    check("abort_regs_flat", bus.regs_flat, flat_regs());
    wb_seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      if (bus.wb_valid) wb_seen = 1'b1;
      tick();
    end
    check("abort_no_wb", 256'(wb_seen), 256'(0));
    check("abort_regs_after_wait", bus.regs_flat, flat_regs());

    v = '{2'd0, 4'd12, 16'd3, 16'd4, 1'b0, 1'b0, 16'd7, 1'b0, 16'h0000};
    issue(v, 1'b1);
    wait_wb(2, "post_reset_add");

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
